mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Stage directly downstream of the execute ALU; consumes the ALU result plus the decoded control for one instruction.
- Executes LW/SW against the data-memory bus with a req/ready handshake and stalls upstream while busy.
- Resolves BEQ/BNE/J redirects from the ALU result.
- Hands a registered result to writeback.

Parameters:
- DATA_W, 32, datapath and address width.
- REG_AW, 5, register index width.
- TIMEOUT, 16, max cycles to wait for mem_ready before aborting (≥2).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result valid this cycle
- in_ready  out  1  stage can accept (high only in IDLE)
- in_opcode  in  6  instruction opcode
- in_alu  in  DATA_W  ALU output: result, effective address, or branch/jump target
- in_store  in  DATA_W  store data (rt value)
- in_rd  in  REG_AW  destination register
- in_wen  in  1  instruction writes a register
- mem_req  out  1  bus request, held until accepted
- mem_we  out  1  1 = store
- mem_addr  out  DATA_W  word-aligned byte address
- mem_wdata  out  DATA_W  store data
- mem_ready  in  1  bus completes the request this cycle
- mem_rdata  in  DATA_W  load data, valid with mem_ready
- wb_valid  out  1  one-cycle pulse, result retires
- wb_wen  out  1  write register file
- wb_rd  out  REG_AW  destination register
- wb_data  out  DATA_W  writeback value
- br_taken  out  1  one-cycle redirect pulse
- br_target  out  DATA_W  redirect PC
- mem_err  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; the timeout counter clears.
  - All outputs are 0 except in_ready=1.
  - Reset mid-transaction drops mem_req immediately; no writeback, no error pulse.
- Accept: the handshake is in_valid && in_ready. Inputs are captured on that edge. Signals without in_valid are ignored.
- Non-memory ops (R-type 000000, ADDI 001000, ANDI 001100):
  - Retire on the next cycle: wb_valid=1, wb_data=in_alu, wb_wen=in_wen, wb_rd=in_rd.
  - Latency 1; throughput 1/cycle; in_ready stays 1.
- BEQ 000100 / BNE 000101:
  - If in_alu≠0: br_taken=1 and br_target=in_alu on the next cycle.
  - If in_alu=0: no redirect.
  - Always wb_valid=1 with wb_wen=0.
- J 000010: br_taken=1, br_target=in_alu, wb_wen=0.
- Unknown opcode: retires as wb_valid=1, wb_wen=0, with no other effect.
- LW 100011 / SW 101011, FSM IDLE -> REQ -> IDLE:
  - On accept, if in_alu[1:0]≠0 (misaligned): no bus activity; next cycle mem_err=1, wb_valid=1, wb_wen=0.
  - Otherwise enter REQ:
    - mem_req=1, mem_addr=in_alu, mem_we=(SW), mem_wdata=in_store.
    - All four are held stable until mem_ready.
    - in_ready=0.
  - REQ with mem_ready=1:
    - Same edge: return to IDLE.
    - Next cycle wb_valid=1.
    - LW: wb_wen=in_wen, wb_data=mem_rdata captured on that edge.
    - SW: wb_wen=0, wb_data=0.
  - Minimum load/store latency is 2 cycles (mem_ready in the first REQ cycle).
  - mem_ready outside REQ is ignored.
- Timeout:
  - The counter increments each REQ cycle without mem_ready.
  - On the REQ cycle where it reaches TIMEOUT-1 with no ready: drop mem_req, return to IDLE.
  - Next cycle: mem_err=1, wb_valid=1, wb_wen=0, wb_data=0.
  - A mem_ready arriving on that same final cycle wins: normal completion, no error.
- Back-to-back:
  - A new instruction can be accepted on the cycle the stage returns to IDLE.
  - in_ready is combinational from state: it rises the cycle after mem_ready.
- wb_valid, br_taken and mem_err are single-cycle pulses; wb_data/wb_rd hold their last value otherwise.

Decomposition:
- Shared package (mips_pkg):
  - Opcode constants OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_LW, OP_SW.
  - State enum {IDLE, REQ}.
  - DATA_W and REG_AW defaults.
- One natural sub-module: mem_bus_ctrl (REQ hold, timeout counter, abort). The top handles decode, the branch redirect and the writeback register.

Test Plan:
- ADDI retire: reset, accept opcode 001000, in_alu=0x0000_0014, rd=8, wen=1 -> next cycle wb_valid=1, wb_data=0x14, wb_rd=8, wb_wen=1; in_ready never drops.
- LW with 3-cycle ready delay: LW addr 0x100 -> mem_req=1, mem_we=0, mem_addr=0x100 held 3 cycles; mem_ready with rdata=0xDEAD_BEEF -> next cycle wb_data=0xDEADBEEF, in_ready low throughout REQ.
- SW then BEQ back-to-back: SW addr 0x40 data 0x55, ready in the 1st cycle -> wb_wen=0. BEQ in_alu=0x200 accepted on the next cycle -> br_taken=1, br_target=0x200. BNE in_alu=0 -> no br_taken.
- Misaligned and timeout:
  - LW addr 0x102 -> no mem_req; mem_err and wb_valid pulse next cycle, wb_wen=0.
  - SW with mem_ready never asserted (TIMEOUT=16) -> mem_req high exactly 16 cycles, then mem_err=1.
- Reset mid-REQ: assert rst_n=0 on the 2nd REQ cycle -> mem_req=0 asynchronously, no wb_valid/mem_err; after release in_ready=1, next ADDI retires normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode constants, state encoding and width defaults for the MIPS-style pipeline.
package mips_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic {IDLE, REQ} mem_state_e;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus sequencer: holds one request stable until mem_ready, aborts after TIMEOUT cycles.
module mem_bus_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              start_we,
  input  logic [DATA_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q;
  logic [DATA_W-1:0] addr_q, wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = REQ;
      end
      REQ: begin
        // A ready on the final counted cycle still completes normally.
        if (mem_ready) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start && (state_q == IDLE)) begin
        we_q    <= start_we;
        addr_q  <= start_addr;
        wdata_q <= start_wdata;
      end
    end
  end

  assign busy      = (state_q == REQ);
  assign mem_req   = busy;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: decodes the ALU result, runs LW/SW on the data bus, resolves branches and
// registers the writeback result.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_store,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_wen,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              mem_err
);

  logic busy, done, abort, accept, misaligned, start;

  assign in_ready   = !busy;
  assign accept     = in_valid && in_ready;
  assign misaligned = (in_alu[1:0] != 2'b00);
  assign start      = accept && is_mem_op(in_opcode) && !misaligned;

  mem_bus_ctrl #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_bus (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_we    (in_opcode == OP_SW),
    .start_addr  (in_alu),
    .start_wdata (in_store),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .done        (done),
    .abort       (abort),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata)
  );

  // Destination info of the in-flight load/store, needed when the bus completes.
  logic              pend_lw_q, pend_wen_q;
  logic [REG_AW-1:0] pend_rd_q;

  logic              wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d, br_target_q, br_target_d;
  logic              br_taken_q, br_taken_d, mem_err_q, mem_err_d;

  always_comb begin
    wb_valid_d  = 1'b0;
    wb_wen_d    = wb_wen_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;
    mem_err_d   = 1'b0;
    if (accept) begin
      unique case (in_opcode)
        OP_RTYPE, OP_ADDI, OP_ANDI: begin
          wb_valid_d = 1'b1;
          wb_wen_d   = in_wen;
          wb_rd_d    = in_rd;
          wb_data_d  = in_alu;
        end
        OP_BEQ, OP_BNE: begin
          wb_valid_d = 1'b1;
          wb_wen_d   = 1'b0;
          wb_rd_d    = in_rd;
          br_taken_d = (in_alu != '0);
          if (in_alu != '0) br_target_d = in_alu;
        end
        OP_J: begin
          wb_valid_d  = 1'b1;
          wb_wen_d    = 1'b0;
          wb_rd_d     = in_rd;
          br_taken_d  = 1'b1;
          br_target_d = in_alu;
        end
        OP_LW, OP_SW: begin
          // Aligned accesses retire later from the bus; misaligned ones fault immediately.
          if (misaligned) begin
            wb_valid_d = 1'b1;
            wb_wen_d   = 1'b0;
            wb_rd_d    = in_rd;
            wb_data_d  = '0;
            mem_err_d  = 1'b1;
          end
        end
        default: begin
          wb_valid_d = 1'b1;
          wb_wen_d   = 1'b0;
          wb_rd_d    = in_rd;
        end
      endcase
    end else if (done) begin
      wb_valid_d = 1'b1;
      wb_wen_d   = pend_lw_q && pend_wen_q;
      wb_rd_d    = pend_rd_q;
      wb_data_d  = pend_lw_q ? mem_rdata : '0;
    end else if (abort) begin
      wb_valid_d = 1'b1;
      wb_wen_d   = 1'b0;
      wb_rd_d    = pend_rd_q;
      wb_data_d  = '0;
      mem_err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_lw_q   <= 1'b0;
      pend_wen_q  <= 1'b0;
      pend_rd_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_wen_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      if (start) begin
        pend_lw_q  <= (in_opcode == OP_LW);
        pend_wen_q <= in_wen;
        pend_rd_q  <= in_rd;
      end
      wb_valid_q  <= wb_valid_d;
      wb_wen_q    <= wb_wen_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_wen    = wb_wen_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases then randomized instruction stream.
module tb_mem_stage;
  import mips_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_wen;
  logic [5:0]    in_opcode;
  logic [DW-1:0] in_alu, in_store;
  logic [AW-1:0] in_rd;
  logic          mem_req, mem_we, mem_ready;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          wb_valid, wb_wen, br_taken, mem_err;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data, br_target;

  mem_stage #(
    .DATA_W  (DW),
    .REG_AW  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_alu    (in_alu),
    .in_store  (in_store),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .wb_valid  (wb_valid),
    .wb_wen    (wb_wen),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .br_taken  (br_taken),
    .br_target (br_target),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected retirement of the most recently completed instruction.
  bit            exp_pend = 1'b0;
  logic          exp_wen, exp_err, exp_br, chk_data, chk_rd;
  logic [DW-1:0] exp_data, exp_tgt;
  logic [AW-1:0] exp_rd;

  logic [5:0] ops [9];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_junk();
    in_opcode = 6'($urandom);
    in_alu    = $urandom;
    in_store  = $urandom;
    in_rd     = 5'($urandom);
    in_wen    = 1'($urandom);
  endtask

  task automatic check_retire(input bit in_req);
    if (exp_pend) begin
      check("wb_valid", 32'(wb_valid), 32'd1);
      check("wb_wen", 32'(wb_wen), 32'(exp_wen));
      if (chk_rd) check("wb_rd", 32'(wb_rd), 32'(exp_rd));
      if (chk_data) check("wb_data", wb_data, exp_data);
      check("br_taken", 32'(br_taken), 32'(exp_br));
      if (exp_br) check("br_target", br_target, exp_tgt);
      check("mem_err", 32'(mem_err), 32'(exp_err));
    end else begin
      check("wb_valid_quiet", 32'(wb_valid), 32'd0);
      check("br_taken_quiet", 32'(br_taken), 32'd0);
      check("mem_err_quiet", 32'(mem_err), 32'd0);
    end
    if (!in_req) check("mem_req_idle", 32'(mem_req), 32'd0);
    exp_pend = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    drive_junk();
    mem_ready = 1'($urandom);
    @(negedge clk);
    check_retire(1'b0);
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 once the instruction has left the stage.
  // delay: REQ cycle index (0-based) in which mem_ready is raised; >= TO means never.
  task automatic issue(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] store,
                       input logic [4:0] rd, input logic wen, input int delay,
                       input logic [31:0] rdata);
    logic e_wen, e_err, e_br, c_data, c_rd, req;
    logic [31:0] e_data, e_tgt;
    in_valid  = 1'b1;
    in_opcode = op;
    in_alu    = alu;
    in_store  = store;
    in_rd     = rd;
    in_wen    = wen;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'd1);
    check_retire(1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive_junk();

    e_wen = 1'b0; e_err = 1'b0; e_br = 1'b0; c_data = 1'b0; c_rd = 1'b0; req = 1'b0;
    e_data = '0; e_tgt = '0;
    case (op)
      OP_RTYPE, OP_ADDI, OP_ANDI: begin
        e_wen = wen; e_data = alu; c_data = 1'b1; c_rd = 1'b1;
      end
      OP_BEQ, OP_BNE: begin e_br = (alu != '0); e_tgt = alu; end
      OP_J: begin e_br = 1'b1; e_tgt = alu; end
      OP_LW, OP_SW: begin
        if (alu[1:0] != 2'b00) e_err = 1'b1;
        else begin
          req = 1'b1;
          if (delay >= int'(TO)) begin
            e_err = 1'b1; e_data = '0; c_data = 1'b1;
          end else if (op == OP_LW) begin
            e_wen = wen; e_data = rdata; c_data = 1'b1; c_rd = 1'b1;
          end else begin
            e_data = '0; c_data = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (req) begin
      for (int k = 0; k < int'(TO); k++) begin
        in_valid  = 1'($urandom);
        mem_ready = (k == delay);
        mem_rdata = (k == delay) ? rdata : $urandom;
        @(negedge clk);
        check("mem_req", 32'(mem_req), 32'd1);
        check("mem_addr", mem_addr, alu);
        check("mem_we", 32'(mem_we), 32'(op == OP_SW));
        check("mem_wdata", mem_wdata, store);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        check_retire(1'b1);
        @(posedge clk); #1;
        if (k == delay) break;
      end
      in_valid  = 1'b0;
      mem_ready = 1'($urandom);
    end

    exp_wen = e_wen; exp_err = e_err; exp_br = e_br; exp_data = e_data; exp_tgt = e_tgt;
    exp_rd = rd; chk_data = c_data; chk_rd = c_rd;
    exp_pend = 1'b1;
  endtask

  initial begin
    int r, delay;
    logic [5:0]  op;
    logic [31:0] alu;
    ops[0] = OP_RTYPE; ops[1] = OP_ADDI; ops[2] = OP_ANDI; ops[3] = OP_BEQ; ops[4] = OP_BNE;
    ops[5] = OP_J; ops[6] = OP_LW; ops[7] = OP_SW; ops[8] = 6'b111111;

    rst_n = 1'b0; in_valid = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    in_opcode = '0; in_alu = '0; in_store = '0; in_rd = '0; in_wen = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_br_taken", 32'(br_taken), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    issue(OP_ADDI, 32'h14, 32'h0, 5'd8, 1'b1, 0, 32'h0);
    issue(OP_LW, 32'h100, 32'h0, 5'd3, 1'b1, 2, 32'hDEAD_BEEF);
    issue(OP_SW, 32'h40, 32'h55, 5'd0, 1'b0, 0, 32'h0);
    issue(OP_BEQ, 32'h200, 32'h0, 5'd0, 1'b0, 0, 32'h0);
    issue(OP_BNE, 32'h0, 32'h0, 5'd0, 1'b0, 0, 32'h0);
    issue(OP_LW, 32'h102, 32'h0, 5'd4, 1'b1, 0, 32'h0);
    issue(OP_SW, 32'h80, 32'h1234, 5'd0, 1'b0, 1000, 32'h0);
    issue(OP_LW, 32'h84, 32'h0, 5'd9, 1'b1, int'(TO) - 1, 32'hCAFE_F00D);
    issue(OP_J, 32'h400, 32'h0, 5'd0, 1'b0, 0, 32'h0);

    // Reset during the second REQ cycle.
    in_valid = 1'b1; in_opcode = OP_LW; in_alu = 32'h88; in_rd = 5'd2; in_wen = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk); check_retire(1'b0);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); check("rreq_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("rreq_mem_req_drop", 32'(mem_req), 32'd0);
    check("rreq_in_ready", 32'(in_ready), 32'd1);
    check("rreq_wb_valid", 32'(wb_valid), 32'd0);
    check("rreq_mem_err", 32'(mem_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycle();
    issue(OP_ADDI, 32'h77, 32'h0, 5'd5, 1'b1, 0, 32'h0);

    for (int n = 0; n < 300; n++) begin
      op  = ops[$urandom_range(0, 8)];
      alu = $urandom;
      if (is_mem_op(op) && ($urandom_range(0, 3) != 0)) alu[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) alu = '0;
      r = $urandom_range(0, 9);
      delay = (r < 7) ? r : ((r == 7) ? int'(TO) - 1 : 40);
      issue(op, alu, $urandom, 5'($urandom), 1'($urandom), delay, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
